// File: rtl/add_rr_pipe_if.sv
// add_rr_pipe_if: operand/result FIFO bundle shared by add_rr_pipe and its host.
// sat_flag exists only when ADD_RR_PIPE_SATURATE_EN is defined.
interface add_rr_pipe_if #(
   parameter int FLUX       = 2,
   parameter int DATA_WIDTH = 27
);
   localparam int TAG_WIDTH = $clog2(FLUX);
   localparam int WIDTH     = DATA_WIDTH + TAG_WIDTH;

   logic [FLUX*WIDTH-1:0] opA_dout;
   logic [FLUX-1:0]       opA_empty;
   logic [FLUX-1:0]       opA_read;
   logic [FLUX*WIDTH-1:0] opB_dout;
   logic [FLUX-1:0]       opB_empty;
   logic [FLUX-1:0]       opB_read;
   logic [WIDTH-1:0]      sum_din;
   logic                  sum_write;
   logic [FLUX-1:0]       sum_full;

`ifdef ADD_RR_PIPE_SATURATE_EN
   logic                  sat_flag;

   modport master (
      output opA_dout, opA_empty, opB_dout, opB_empty, sum_full,
      input  opA_read, opB_read, sum_din, sum_write, sat_flag
   );

   modport slave (
      input  opA_dout, opA_empty, opB_dout, opB_empty, sum_full,
      output opA_read, opB_read, sum_din, sum_write, sat_flag
   );
`else
   modport master (
      output opA_dout, opA_empty, opB_dout, opB_empty, sum_full,
      input  opA_read, opB_read, sum_din, sum_write
   );

   modport slave (
      input  opA_dout, opA_empty, opB_dout, opB_empty, sum_full,
      output opA_read, opB_read, sum_din, sum_write
   );
`endif
endinterface

// File: rtl/add_rr_pipe.sv
// add_rr_pipe: FLUX-channel round-robin add/sub with a registered result stage.
// Optional clamp on overflow with ADD_RR_PIPE_SATURATE_EN (adds sat_flag).
module add_rr_pipe #(
   parameter int FLUX       = 2,
   parameter int DATA_WIDTH = 27,
   parameter int OP_SUB     = 0
) (
   input logic          clk,
   input logic          rst,
   add_rr_pipe_if.slave bus
);
   localparam int TAG_WIDTH = $clog2(FLUX);
   localparam int WIDTH     = DATA_WIDTH + TAG_WIDTH;

   logic [FLUX-1:0]              elig;
   logic                         hit_hi, hit_lo, found;
   logic [TAG_WIDTH-1:0]         win_hi, win_lo, win;
   logic                         full_sel, drain, accept, fire;
   logic signed [DATA_WIDTH-1:0] a_op, b_op, res;
   logic                         unused_tags;

   logic                         r_valid_q, r_valid_d;
   logic [TAG_WIDTH-1:0]         r_tag_q, r_tag_d;
   logic [DATA_WIDTH-1:0]        r_data_q, r_data_d;
   logic [TAG_WIDTH-1:0]         rr_ptr_q, rr_ptr_d;

   assign elig = ~bus.opA_empty & ~bus.opB_empty & ~bus.sum_full;

   // Split the search at rr_ptr: lowest eligible at/above it wins, else lowest below
   always_comb begin
      hit_hi = 1'b0;
      hit_lo = 1'b0;
      win_hi = '0;
      win_lo = '0;
      for (int c = FLUX - 1; c >= 0; c--) begin
         if (elig[c]) begin
            if (TAG_WIDTH'(c) >= rr_ptr_q) begin
               hit_hi = 1'b1;
               win_hi = TAG_WIDTH'(c);
            end else begin
               hit_lo = 1'b1;
               win_lo = TAG_WIDTH'(c);
            end
         end
      end
   end

   assign found = hit_hi | hit_lo;
   assign win   = hit_hi ? win_hi : win_lo;

   // Full flag of the lane the held result is headed for
   always_comb begin
      full_sel = 1'b0;
      for (int c = 0; c < FLUX; c++) begin
         if (r_tag_q == TAG_WIDTH'(c)) full_sel = bus.sum_full[c];
      end
   end

   assign drain  = r_valid_q & ~full_sel & ~rst;
   assign accept = ~r_valid_q | drain;
   assign fire   = found & accept & ~rst;

   // Winner's operand data fields; incoming tag bits are dropped
   always_comb begin
      a_op        = '0;
      b_op        = '0;
      unused_tags = 1'b0;
      for (int c = 0; c < FLUX; c++) begin
         unused_tags = unused_tags
                     ^ (^bus.opA_dout[c*WIDTH+DATA_WIDTH +: TAG_WIDTH])
                     ^ (^bus.opB_dout[c*WIDTH+DATA_WIDTH +: TAG_WIDTH]);
         if (win == TAG_WIDTH'(c)) begin
            a_op = bus.opA_dout[c*WIDTH +: DATA_WIDTH];
            b_op = bus.opB_dout[c*WIDTH +: DATA_WIDTH];
         end
      end
   end

   // One-hot pop strobes for the winner on a fire cycle
   always_comb begin
      bus.opA_read = '0;
      bus.opB_read = '0;
      for (int c = 0; c < FLUX; c++) begin
         bus.opA_read[c] = fire && (win == TAG_WIDTH'(c));
         bus.opB_read[c] = fire && (win == TAG_WIDTH'(c));
      end
   end

`ifdef ADD_RR_PIPE_SATURATE_EN
   logic signed [DATA_WIDTH:0] wide;
   logic                       sat;
   logic                       sat_q, sat_d;

   // One extra bit exposes overflow; clamp toward the sign of the true result
   always_comb begin
      if (OP_SUB != 0) begin
         wide = {a_op[DATA_WIDTH-1], a_op} - {b_op[DATA_WIDTH-1], b_op};
      end else begin
         wide = {a_op[DATA_WIDTH-1], a_op} + {b_op[DATA_WIDTH-1], b_op};
      end
      sat = wide[DATA_WIDTH] ^ wide[DATA_WIDTH-1];
      res = wide[DATA_WIDTH-1:0];
      if (sat) begin
         res = wide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
   end

   // Flag travels with the result it describes
   always_comb begin
      sat_d = sat_q;
      if (fire) sat_d = sat;
   end

   // Flag register
   always_ff @(posedge clk) begin
      if (rst) sat_q <= 1'b0;
      else     sat_q <= sat_d;
   end

   assign bus.sat_flag = sat_q;
`else
   // Plain two's-complement wrap at DATA_WIDTH
   always_comb begin
      if (OP_SUB != 0) res = a_op - b_op;
      else             res = a_op + b_op;
   end
`endif

   // Reload on fire (also covers same-cycle drain), otherwise empty on drain
   always_comb begin
      r_valid_d = r_valid_q;
      r_tag_d   = r_tag_q;
      r_data_d  = r_data_q;
      rr_ptr_d  = rr_ptr_q;
      if (fire) begin
         r_valid_d = 1'b1;
         r_tag_d   = win;
         r_data_d  = res;
         rr_ptr_d  = (win == TAG_WIDTH'(FLUX - 1)) ? '0 : win + 1'b1;
      end else if (drain) begin
         r_valid_d = 1'b0;
      end
   end

   // Result register and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid_q <= 1'b0;
         r_tag_q   <= '0;
         r_data_q  <= '0;
         rr_ptr_q  <= '0;
      end else begin
         r_valid_q <= r_valid_d;
         r_tag_q   <= r_tag_d;
         r_data_q  <= r_data_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   assign bus.sum_din   = {r_tag_q, r_data_q};
   assign bus.sum_write = drain;
endmodule
